// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the fetch/data masters, the arbiter and the single-port data RAM.
interface ram_access_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rsp_data;
    logic                  err;

    logic                  ram_enable;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, ram_data_out,
        output i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
               err, ram_enable, ram_write, ram_addr, ram_data_in
    );

    // Masters plus RAM side
    modport master (
        output i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, ram_data_out,
        input  i_req_ready, i_rsp_valid, i_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
               err, ram_enable, ram_write, ram_addr, ram_data_in
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Fetch/data two-master arbiter in front of the 4K x 16 data RAM, one access in flight.
// Optional macro RAM_ADDR_CHECK_EN: flag and suppress accesses above the implemented range.
module ram_access_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_BITS  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_access_arbiter_if.slave bus
);
    localparam int unsigned AW = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio_d;
    logic                  r_owner_d;
    logic                  r_err;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_accept;
    logic                  w_oor;
    logic [AW-1:0]         w_sel_addr;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Grant is combinational from the VALIDs, only in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.d_req_valid && (!bus.i_req_valid || r_prio_d)) begin
                    w_grant_d = 1'b1;
                end else if (bus.i_req_valid) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d || w_grant_i) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept        = w_grant_d | w_grant_i;
    assign w_sel_addr      = w_grant_d ? bus.d_addr : bus.i_addr;
    assign bus.i_req_ready = w_grant_i;
    assign bus.d_req_ready = w_grant_d;
    assign w_rsp_data      = r_err ? DATA_WIDTH'(0) : bus.ram_data_out;

`ifdef RAM_ADDR_CHECK_EN
    assign w_oor = |w_sel_addr[AW-1:ADDR_BITS];
`else
    assign w_oor = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the granted request and present it to the RAM for the ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_d        <= 1'b1;
            r_owner_d       <= 1'b0;
            r_err           <= 1'b0;
            bus.ram_enable  <= 1'b0;
            bus.ram_write   <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_data_in <= '0;
        end else if (w_accept) begin
            r_owner_d      <= w_grant_d;
            r_prio_d       <= w_grant_i;
            r_err          <= w_oor;
            bus.ram_enable <= !w_oor;
            bus.ram_write  <= w_grant_d & bus.d_we & !w_oor;
            bus.ram_addr   <= w_sel_addr;
            if (w_grant_d) begin
                bus.ram_data_in <= bus.d_wdata;
            end
        end else begin
            bus.ram_enable <= 1'b0;
            bus.ram_write  <= 1'b0;
        end
    end

    // RAM word is valid during RESP; register it into the owner's response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_rsp_valid <= 1'b0;
            bus.d_rsp_valid <= 1'b0;
            bus.i_rsp_data  <= '0;
            bus.d_rsp_data  <= '0;
            bus.err         <= 1'b0;
        end else if (r_state == S_RESP) begin
            bus.i_rsp_valid <= !r_owner_d;
            bus.d_rsp_valid <= r_owner_d;
            bus.err         <= r_err;
            if (r_owner_d) begin
                bus.d_rsp_data <= w_rsp_data;
            end else begin
                bus.i_rsp_data <= w_rsp_data;
            end
        end else begin
            bus.i_rsp_valid <= 1'b0;
            bus.d_rsp_valid <= 1'b0;
            bus.err         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a RAM model and response scoreboard.
module tb_ram_access_arbiter;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_access_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    ram_access_arbiter #(.DATA_WIDTH(16), .ADDR_BITS(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          is_d;
        logic [15:0] data;
        logic        err;
        int          hs;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem    [4096];
    logic [15:0] shadow [4096];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered RAM: data out valid the cycle after an enabled access
    always @(posedge clk) begin
        if (bus.ram_enable) begin
            if (bus.ram_write) begin
                mem[bus.ram_addr[11:0]] <= bus.ram_data_in;
                bus.ram_data_out        <= bus.ram_data_in;
            end else begin
                bus.ram_data_out <= mem[bus.ram_addr[11:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [15:0] a);
`ifdef RAM_ADDR_CHECK_EN
        return a[15:12] != 4'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t make_exp(input bit is_d, input bit we, input logic [15:0] addr,
                                      input logic [15:0] wdata, input int hs);
        exp_t e;
        bit   oor;
        oor    = out_of_range(addr);
        e.is_d = is_d;
        e.err  = oor;
        e.hs   = hs;
        if (oor)             e.data = 16'h0000;
        else if (is_d && we) e.data = wdata;
        else                 e.data = shadow[addr[11:0]];
        if (is_d && we && !oor) shadow[addr[11:0]] = wdata;
        return e;
    endfunction

    // Response checker: pops the oldest expectation on every response pulse
    always @(negedge clk) begin
        if (rst_n && (bus.i_rsp_valid || bus.d_rsp_valid)) begin
            chk("rsp_overlap", 32'(bus.i_rsp_valid & bus.d_rsp_valid), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_port", 32'(bus.d_rsp_valid), 32'(mon_e.is_d));
                chk("rsp_data", 32'(mon_e.is_d ? bus.d_rsp_data : bus.i_rsp_data), 32'(mon_e.data));
                chk("rsp_err", 32'(bus.err), 32'(mon_e.err));
                chk("rsp_latency", 32'(cyc), 32'(mon_e.hs + 2));
            end
        end
    end

    task automatic issue(input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit expect_rsp);
        int   n;
        logic rdy;
        bit   oor;
        oor = out_of_range(addr);
        @(negedge clk);
        if (is_d) begin
            bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req_valid = 1'b1;
        end else begin
            bus.i_addr = addr; bus.i_req_valid = 1'b1;
        end
        #1;
        n   = 0;
        rdy = is_d ? bus.d_req_ready : bus.i_req_ready;
        while (!rdy && n < 30) begin
            @(negedge clk); #1;
            n++;
            rdy = is_d ? bus.d_req_ready : bus.i_req_ready;
        end
        chk("req_ready", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        if (expect_rsp) sb.push_back(make_exp(is_d, we, addr, wdata, cyc));
        bus.d_req_valid = 1'b0;
        bus.i_req_valid = 1'b0;
        chk("ram_enable", 32'(bus.ram_enable), 32'(!oor));
        chk("ram_write", 32'(bus.ram_write), 32'(is_d && we && !oor));
        chk("ram_addr", 32'(bus.ram_addr), 32'(addr));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   n;
        int   prev_hs;
        bit   exp_d;
        logic rd, ri;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 16'(i) ^ 16'h5A5A;
            shadow[i] = 16'(i) ^ 16'h5A5A;
        end
        bus.i_req_valid = 1'b0; bus.i_addr = '0;
        bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_data_out = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_ram_enable", 32'(bus.ram_enable), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_rsp_valid", 32'({bus.i_rsp_valid, bus.d_rsp_valid}), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rsp_data", 32'({bus.i_rsp_data, bus.d_rsp_data}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset in the middle of a store: access dropped, no response, old data kept
        issue(1'b1, 1'b1, 16'h0010, 16'hDEAD, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ram_enable", 32'(bus.ram_enable), 32'd0);
        chk("midrst_ram_addr", 32'(bus.ram_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);

        // Store then fetch of the same word
        issue(1'b1, 1'b1, 16'h0123, 16'hBEEF, 1'b1);
        issue(1'b0, 1'b0, 16'h0123, 16'h0000, 1'b1);

        // Loads at the top and bottom of the array
        issue(1'b1, 1'b0, 16'h0FFF, 16'h0000, 1'b1);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Upper address bits: alias without the check, error with it
        issue(1'b1, 1'b1, 16'h1005, 16'h1234, 1'b1);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
        drain();

        // Both masters requesting every cycle from reset: grants alternate from D
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.d_we = 1'b0; bus.d_addr = 16'h0200; bus.i_addr = 16'h0300;
        bus.d_req_valid = 1'b1; bus.i_req_valid = 1'b1;
        exp_d   = 1'b1;
        prev_hs = -1;
        for (int g = 0; g < 6; g++) begin
            #1;
            n  = 0;
            rd = bus.d_req_ready; ri = bus.i_req_ready;
            while (!(rd || ri) && n < 10) begin
                @(negedge clk); #1;
                n++;
                rd = bus.d_req_ready; ri = bus.i_req_ready;
            end
            chk("grant_order", 32'({rd, ri}), 32'({exp_d, !exp_d}));
            @(posedge clk); #1;
            if (prev_hs >= 0) chk("grant_spacing", 32'(cyc - prev_hs), 32'd3);
            prev_hs = cyc;
            sb.push_back(make_exp(exp_d, 1'b0, exp_d ? 16'h0200 : 16'h0300, 16'h0000, cyc));
            exp_d = !exp_d;
            @(negedge clk);
        end
        bus.d_req_valid = 1'b0; bus.i_req_valid = 1'b0;
        drain();

        // Fetch raised during RESP becomes eligible in the next IDLE cycle
        issue(1'b1, 1'b0, 16'h0123, 16'h0000, 1'b1);
        @(posedge clk); #1;
        bus.i_addr = 16'h0FFF; bus.i_req_valid = 1'b1;
        #1;
        chk("resp_i_ready", 32'(bus.i_req_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_i_ready", 32'(bus.i_req_ready), 32'd1);
        @(posedge clk); #1;
        sb.push_back(make_exp(1'b0, 1'b0, 16'h0FFF, 16'h0000, cyc));
        bus.i_req_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
